// File: rtl/line_fill_arbiter.sv
// line_fill_arbiter: grants the single pipelined main memory to an I-line fill, a D-line fill or a D-side store
// Build option: define ARB_ROUND_ROBIN_EN to alternate I-side and D-side grants on ties (default: fixed I > D-fill > store).
// Ports:
//   clk, rst                           clock and asynchronous active-high reset
//   i_miss/i_miss_addr                 I-cache fill request and miss byte address
//   d_miss/d_miss_addr                 D-cache fill request and miss byte address
//   d_wr_req/d_wr_addr/d_wr_data       D-side write-through store
//   mem_en/mem_wr/mem_addr/mem_wdata   memory request channel
//   mem_rdata/mem_valid                memory read return channel
//   fill_i_we/fill_d_we/fill_addr/fill_data  returned-word strobes to the owning cache
//   i_done/d_done/d_wr_ack             completion pulses
//   i_busy/d_busy                      stall requests to fetch and memory stages
module line_fill_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              fill_i_we,
    output logic              fill_d_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_done,
    output logic              d_done,
    output logic              d_wr_ack,
    output logic              i_busy,
    output logic              d_busy
);
    localparam int OFS = $clog2(WORDS) + 1;
    localparam logic [OFS-1:0] NW = OFS'(WORDS);
    localparam logic [OFS-1:0] NL = OFS'(WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFS){1'b1}}, {OFS{1'b0}}};

    if (MEM_LAT < 1 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_cfg
        $error("line_fill_arbiter: WORDS must be a power of 2 >= 2 and MEM_LAT >= 1");
    end

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wdata;
    logic              owner_d;
    logic [OFS-1:0]    iss_cnt;
    logic [OFS-1:0]    ret_cnt;
    logic              grant_i;
    logic              issuing;
    logic              ret;

`ifdef ARB_ROUND_ROBIN_EN
    // last_d remembers which side won the previous grant; the other side wins a tie
    logic last_d;
    assign grant_i = i_miss && (!(d_miss || d_wr_req) || last_d);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            last_d <= 1'b1;
        else if (state == IDLE && (i_miss || d_miss || d_wr_req))
            last_d <= !grant_i;
`else
    assign grant_i = i_miss;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            wdata   <= '0;
            owner_d <= 1'b0;
            iss_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    iss_cnt <= '0;
                    ret_cnt <= '0;
                    if (grant_i) begin
                        state   <= FILL;
                        owner_d <= 1'b0;
                        base    <= i_miss_addr & LINE_MASK;
                    end else if (d_miss) begin
                        state   <= FILL;
                        owner_d <= 1'b1;
                        base    <= d_miss_addr & LINE_MASK;
                    end else if (d_wr_req) begin
                        state   <= WRITE;
                        owner_d <= 1'b1;
                        base    <= d_wr_addr;
                        wdata   <= d_wr_data;
                    end
                end
                FILL: begin
                    if (issuing) iss_cnt <= iss_cnt + 1'b1;
                    if (ret) ret_cnt <= ret_cnt + 1'b1;
                    if (ret && ret_cnt == NL) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // line offsets are ORed into the cleared low bits so a fill never leaves its aligned block
    assign issuing   = state == FILL && iss_cnt < NW;
    assign ret       = state == FILL && mem_valid && ret_cnt < NW;
    assign mem_en    = issuing || state == WRITE;
    assign mem_wr    = state == WRITE;
    assign mem_addr  = state == WRITE ? base : issuing ? base | ADDR_W'({iss_cnt[OFS-2:0], 1'b0}) : '0;
    assign mem_wdata = state == WRITE ? wdata : '0;
    assign fill_i_we = ret && !owner_d;
    assign fill_d_we = ret && owner_d;
    assign fill_addr = ret ? base | ADDR_W'({ret_cnt[OFS-2:0], 1'b0}) : '0;
    assign fill_data = ret ? mem_rdata : '0;
    assign i_done    = state == DONE && !owner_d;
    assign d_done    = state == DONE && owner_d;
    assign d_wr_ack  = state == WRITE;
    assign i_busy    = i_miss || (!owner_d && state != IDLE);
    assign d_busy    = d_miss || d_wr_req || (owner_d && state != IDLE);
endmodule

// File: tb/tb_line_fill_arbiter.sv
// tb_line_fill_arbiter: directed checks of fills, stores, collisions, top-of-memory wrap, reset mid-fill and arbitration
module tb_line_fill_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
    logic        mem_en, mem_wr, mem_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        fill_i_we, fill_d_we, i_done, d_done, d_wr_ack, i_busy, d_busy;
    logic [15:0] fill_addr, fill_data;
    logic [3:0]        pv = 4'b0;
    logic [3:0][15:0]  pa = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          nv;

    always #5 clk = ~clk;

    line_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_i_we(fill_i_we), .fill_d_we(fill_d_we), .fill_addr(fill_addr), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack),
        .i_busy(i_busy), .d_busy(d_busy)
    );

    // 4-cycle pipelined memory: returns address ^ A5C3 for every read, never reset
    always @(posedge clk) begin
        pv <= {pv[2:0], mem_en & ~mem_wr};
        pa <= {pa[2:0], mem_addr};
    end
    assign mem_valid = pv[3];
    assign mem_rdata = pv[3] ? pa[3] ^ 16'hA5C3 : 16'h0;

    function automatic logic [63:0] pk(input logic en, wr, input logic [15:0] a,
                                       input logic fi, fd, input logic [15:0] fa, fdat,
                                       input logic id, dd, ack);
        return {9'b0, en, wr, a, fi, fd, fa, fdat, id, dd, ack};
    endfunction

    function automatic logic [63:0] snap();
        return pk(mem_en, mem_wr, mem_addr, fill_i_we, fill_d_we, fill_addr, fill_data, i_done, d_done, d_wr_ack);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grant happens on the next posedge; t counts negedges after it. Issue t=1..8,
    // returns t=5..12, done at t=13, IDLE at t=14.
    task automatic fill(input logic [15:0] base, input logic is_d, input logic drop, input string tag);
        for (int t = 1; t <= 14; t++) begin
            logic en, fv;
            logic [15:0] a, fa;
            @(negedge clk);
            en = t <= 8;
            fv = t >= 5 && t <= 12;
            a  = en ? base + 16'(2 * (t - 1)) : 16'h0;
            fa = fv ? base + 16'(2 * (t - 5)) : 16'h0;
            chk($sformatf("%s_t%0d", tag, t), snap(),
                pk(en, 1'b0, a, fv && !is_d, fv && is_d, fa, fv ? fa ^ 16'hA5C3 : 16'h0,
                   t == 13 && !is_d, t == 13 && is_d, 1'b0));
            chk($sformatf("%s_busy_t%0d", tag, t), {62'b0, i_busy, d_busy},
                {62'b0, i_miss || (!is_d && t <= 13), d_miss || d_wr_req || (is_d && t <= 13)});
            if (drop && t == 3) begin
                if (is_d) d_miss = 1'b0;
                else i_miss = 1'b0;
            end
        end
    endtask

    initial begin
        @(negedge clk);
        chk("reset_outputs", snap(), 64'h0);
        chk("reset_busy", {62'b0, i_busy, d_busy}, 64'h0);
        chk("reset_wdata", {48'b0, mem_wdata}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", snap(), 64'h0);

        i_miss = 1'b1; i_miss_addr = 16'h1236;
        fill(16'h1230, 1'b0, 1'b1, "ifill");

        d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
        @(negedge clk);
        chk("store", snap(), pk(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1));
        chk("store_wdata", {48'b0, mem_wdata}, {48'b0, 16'hBEEF});
        chk("store_busy", {62'b0, i_busy, d_busy}, 64'h1);
        d_wr_req = 1'b0;
        @(negedge clk);
        chk("store_idle", snap(), 64'h0);
        chk("store_idle_busy", {62'b0, i_busy, d_busy}, 64'h0);

        i_miss = 1'b1; i_miss_addr = 16'h8000;
        d_miss = 1'b1; d_miss_addr = 16'h4000;
        fill(16'h8000, 1'b0, 1'b1, "coll_i");
        fill(16'h4000, 1'b1, 1'b1, "coll_d");

        d_miss = 1'b1; d_miss_addr = 16'hFFFA;
        fill(16'hFFF0, 1'b1, 1'b1, "wrap");

        i_miss = 1'b1; i_miss_addr = 16'h2468;
        repeat (7) @(negedge clk);
        chk("rst_third_word", snap(), pk(1'b1, 1'b0, 16'h246C, 1'b1, 1'b0, 16'h2464, 16'h2464 ^ 16'hA5C3, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        #1;
        chk("rst_async", snap(), 64'h0);
        nv = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_valid) nv++;
            chk("rst_late", snap(), 64'h0);
        end
        chk("rst_late_valid_count", 64'(nv), 64'd3);
        rst = 1'b0;
        fill(16'h2460, 1'b0, 1'b1, "rst_restart");

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_miss = 1'b1; i_miss_addr = 16'h1000;
        d_miss = 1'b1; d_miss_addr = 16'h2000;
        fill(16'h1000, 1'b0, 1'b0, "arb1");
`ifdef ARB_ROUND_ROBIN_EN
        fill(16'h2000, 1'b1, 1'b0, "arb2");
        fill(16'h1000, 1'b0, 1'b0, "arb3");
        fill(16'h2000, 1'b1, 1'b0, "arb4");
`else
        fill(16'h1000, 1'b0, 1'b0, "arb2");
`endif
        i_miss = 1'b0;
        d_miss = 1'b0;
        @(negedge clk);
        chk("final_idle", snap(), 64'h0);
        chk("final_busy", {62'b0, i_busy, d_busy}, 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
